linescanner_line_packer: RTL and testbench
==========================================

// Module: linescanner_line_packer
// PURPOSE
//  Downstream of the line-scanner capture unit. Takes its pixel_data/lval stream, sampled once per pixel_clock.
//  Packs 8-bit pixels 4-per-32-bit word and checks each line's length against LINE_PIXELS.
//  Buffers the words in a FIFO and presents them on a valid/ready stream with start-of-line/end-of-line tags for the DMA/processing stage.
// PARAMETERS
//  LINE_PIXELS  1024  expected pixels per line (multiple of 4 not required)
//  FIFO_DEPTH   16    output FIFO depth in words (power of 2, >=4)
// PORTS
//  pixel_clock   in   1   sole clock; all logic on rising edge
//  reset         in   1   synchronous, active-high
//  enable        in   1   capture enable, sampled only at line start
//  lval          in   1   line valid from capture unit; 1 pixel per cycle while high
//  pixel_data    in   8   pixel value, valid when lval=1
//  word_data     out  32  packed pixels, first pixel in [7:0]
//  word_sol      out  1   word is first of a line
//  word_eol      out  1   word is last of a line
//  word_valid    out  1   output word available
//  word_ready    in   1   consumer accepts word when valid&ready
//  line_error    out  1   1-cycle pulse: bad line (short/long/overflow/gap)
//  overflow      out  1   sticky: a word was dropped because FIFO was full; cleared only by reset
//  line_count    out  16  completed lines (eol written), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: word_valid=0, line_error=0, overflow=0, line_count=0, FIFO empty, FSM=IDLE, word_data/sol/eol=0.
//  FSM states and transitions:
//   IDLE:
//    lval rising (lval=1, lval_q=0) & enable -> CAPTURE; that pixel is accepted.
//    lval rising & !enable -> SKIP.
//   CAPTURE: each lval=1 cycle accepts one pixel into the pack register at lane pix_cnt[1:0]; pix_cnt increments.
//    pix_cnt==LINE_PIXELS: extra pixels are dropped and long_flag is set.
//   SKIP: ignore pixels until lval=0 -> IDLE. No output, no error.
//   FLUSH: one cycle; writes the pending partial word with eol=1 -> IDLE.
//  Word staging: a completed 4-pixel word moves to the hold register (hold_valid=1).
//   The hold register is written to the FIFO on the next accepted pixel, with eol=0.
//   Pixels 1..4 of a line set sol on their word.
//   Line end (lval=0 in CAPTURE):
//    - partial word pending: write hold this cycle (eol=0), then go to FLUSH, which writes the zero-padded partial word with eol=1.
//    - no partial word: write hold with eol=1 this cycle -> IDLE.
//    - 0 words in line: impossible; the first pixel is always accepted.
//  line_error pulses on the eol-write cycle if any of the following held for the line:
//   pix_cnt!=LINE_PIXELS at end, long_flag, or a word was dropped.
//  line_count increments on the eol-write cycle, even when the line had an error.
//  FIFO full on a write: the word is dropped, overflow is set, and the line is flagged.
//   An eol word is never dropped silently: if it is dropped, line_error still pulses and line_count still increments.
//  lval rising during FLUSH (gap <2 cycles):
//   - FLUSH completes.
//   - line_error pulses for the new line.
//   - The new line goes to SKIP.
//  enable falling mid-line: the current line completes normally.
//  Output timing:
//   - FIFO write on cycle N -> word_valid=1 at N+1 if the FIFO was empty.
//   - word_data/sol/eol stay stable while valid & !ready.
//   - Simultaneous read and write on a full FIFO: the write succeeds.
//  Reset mid-line: everything is discarded, the FIFO is emptied, and the FSM returns to IDLE.
//   If lval is still high when reset is released, the rest of that line is treated as SKIP.
// STRUCTURE
//  Shared package linescanner_pkg:
//   - FSM state localparams LP_IDLE/LP_CAPTURE/LP_SKIP/LP_FLUSH.
//   - LP_WORD_W=32.
//   - Pixel width 8.
//  Sub-module linescanner_word_fifo: synchronous FIFO, width 34 ({sol,eol,data}), depth FIFO_DEPTH.
//   Ports: full/empty, wr_en/rd_en; registered output.
//  Top level: FSM, pack/hold registers, counters, error logic.
// TESTING
//  1. LINE_PIXELS=8, enable=1, 8 pixels 0x01..0x08, ready=1:
//     2 words, 0x04030201 (sol=1) and 0x08070605 (eol=1); line_count=1; no line_error.
//  2. 6-pixel line 0xA0..0xA5:
//     0xA3A2A1A0 (sol), then 0x0000A5A4 (eol); line_error pulses once.
//  3. 10-pixel line: first 8 pixels output as in test 1; pixels 9-10 dropped; line_error pulses.
//  4. word_ready=0 for 6 lines of 8 pixels, FIFO_DEPTH=8:
//     the first 8 words are kept; overflow=1; line_error on lines 5 and 6; line_count=6.
//  5. enable=0 at the lval rise of line 2 of 3: only lines 1 and 3 are output; line_count=2.
//  6. reset asserted mid-line: word_valid=0 next cycle; lval still high -> no output until the next lval rise.

Source files
------------

// File: rtl/linescanner_pkg.sv
// Shared types and constants for the line-scanner packing path.
package linescanner_pkg;

  // Packer FSM states
  typedef enum logic [1:0] {
    LP_IDLE    = 2'd0,
    LP_CAPTURE = 2'd1,
    LP_SKIP    = 2'd2,
    LP_FLUSH   = 2'd3
  } lp_state_t;

  localparam int LP_WORD_W = 32;
  localparam int LP_PIX_W  = 8;
  localparam int LP_FIFO_W = LP_WORD_W + 2;

  // FIFO entry layout: {sol, eol, data}
  function automatic logic [LP_FIFO_W-1:0] fifo_entry(input logic sol,
                                                      input logic eol,
                                                      input logic [LP_WORD_W-1:0] data);
    return {sol, eol, data};
  endfunction

endpackage

// File: rtl/linescanner_word_fifo.sv
// Synchronous word FIFO with a registered head-of-queue output.
// The output register always mirrors the oldest stored entry, so the
// full capacity is DEPTH entries and valid rises the cycle after the
// first write into an empty FIFO.
module linescanner_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34
) (
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    next_rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             wr_ok;
  logic             rd_ok;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign rd_ok       = rd_en & ~empty;
  assign wr_ok       = wr_en & (~full | rd_ok);
  assign next_rd_ptr = rd_ptr + AW'(1);

  // Occupancy after this cycle's accepted read/write
  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage array; contents need no reset since occupancy guards reads
  always_ff @(posedge pixel_clock) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head-of-queue output
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      count    <= count_next;
      rd_valid <= (count_next != '0);
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= next_rd_ptr;
      end
      if (wr_ok && (empty || (count == CW'(1) && rd_ok))) begin
        rd_data <= wr_data;
      end else if (rd_ok) begin
        rd_data <= mem[next_rd_ptr];
      end
    end
  end

endmodule

// File: rtl/linescanner_line_packer.sv
// Packs the capture unit's 8-bit pixel stream four-per-word, checks line
// length, and queues tagged words (sol/eol) for the downstream stage.
module linescanner_line_packer
  import linescanner_pkg::*;
#(
  parameter int LINE_PIXELS = 1024,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                 pixel_clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 lval,
  input  logic [LP_PIX_W-1:0]  pixel_data,
  output logic [LP_WORD_W-1:0] word_data,
  output logic                 word_sol,
  output logic                 word_eol,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 line_error,
  output logic                 overflow,
  output logic [15:0]          line_count
);

  // Wide enough to hold LINE_PIXELS and the constant 4
  localparam int CNT_W = $clog2(LINE_PIXELS + 5);

  lp_state_t             state;
  logic                  lval_q;
  logic [CNT_W-1:0]      pix_cnt;
  logic [LP_WORD_W-1:0]  pack;
  logic [LP_WORD_W-1:0]  hold_data;
  logic                  hold_sol;
  logic                  hold_valid;
  logic                  long_flag;
  logic                  drop_flag;
  logic                  gap_pending;

  logic                  rising;
  logic                  accept;
  logic                  partial;
  logic                  first_word;
  logic                  wr_en;
  logic                  wr_sol;
  logic                  wr_eol;
  logic [LP_WORD_W-1:0]  wr_word;
  logic [LP_FIFO_W-1:0]  wr_entry;
  logic [LP_FIFO_W-1:0]  fifo_rd;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_read;
  logic                  drop;
  logic                  eol_write;
  logic                  line_bad;

  assign rising     = lval & ~lval_q;
  assign accept     = (pix_cnt != CNT_W'(LINE_PIXELS));
  assign partial    = (pix_cnt[1:0] != 2'b00);
  assign first_word = (pix_cnt < CNT_W'(4));
  assign wr_entry   = fifo_entry(wr_sol, wr_eol, wr_word);
  assign fifo_read  = word_ready & ~fifo_empty;
  assign drop       = wr_en & fifo_full & ~fifo_read;
  assign eol_write  = wr_en & wr_eol;
  assign line_bad   = (pix_cnt != CNT_W'(LINE_PIXELS)) | long_flag | drop_flag | drop;

  assign word_data = fifo_rd[LP_WORD_W-1:0];
  assign word_eol  = fifo_rd[LP_WORD_W];
  assign word_sol  = fifo_rd[LP_WORD_W+1];

  // Decide which word (hold or flushed partial) goes to the FIFO this cycle
  always_comb begin
    wr_en   = 1'b0;
    wr_sol  = 1'b0;
    wr_eol  = 1'b0;
    wr_word = '0;
    case (state)
      LP_CAPTURE: begin
        if (lval) begin
          if (accept && hold_valid) begin
            wr_en   = 1'b1;
            wr_sol  = hold_sol;
            wr_word = hold_data;
          end
        end else if (hold_valid) begin
          wr_en   = 1'b1;
          wr_sol  = hold_sol;
          wr_eol  = ~partial;
          wr_word = hold_data;
        end
      end
      LP_FLUSH: begin
        wr_en   = 1'b1;
        wr_sol  = first_word;
        wr_eol  = 1'b1;
        wr_word = pack;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Packer FSM, staging registers, line bookkeeping and error reporting
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state       <= LP_IDLE;
      lval_q      <= lval;
      pix_cnt     <= '0;
      pack        <= '0;
      hold_data   <= '0;
      hold_sol    <= 1'b0;
      hold_valid  <= 1'b0;
      long_flag   <= 1'b0;
      drop_flag   <= 1'b0;
      gap_pending <= 1'b0;
      line_error  <= 1'b0;
      overflow    <= 1'b0;
      line_count  <= '0;
    end else begin
      lval_q      <= lval;
      line_error  <= gap_pending;
      gap_pending <= 1'b0;

      if (drop) begin
        overflow  <= 1'b1;
        drop_flag <= 1'b1;
      end

      if (eol_write) begin
        line_count <= line_count + 16'd1;
        if (line_bad) begin
          line_error <= 1'b1;
        end
      end

      case (state)
        LP_IDLE: begin
          if (rising) begin
            if (enable) begin
              state      <= LP_CAPTURE;
              pack       <= {{(LP_WORD_W-LP_PIX_W){1'b0}}, pixel_data};
              pix_cnt    <= CNT_W'(1);
              long_flag  <= 1'b0;
              drop_flag  <= 1'b0;
              hold_valid <= 1'b0;
            end else begin
              state <= LP_SKIP;
            end
          end
        end
        LP_CAPTURE: begin
          if (lval) begin
            if (accept) begin
              pix_cnt <= pix_cnt + CNT_W'(1);
              if (pix_cnt[1:0] == 2'b11) begin
                hold_data  <= {pixel_data, pack[LP_WORD_W-LP_PIX_W-1:0]};
                hold_sol   <= first_word;
                hold_valid <= 1'b1;
                pack       <= '0;
              end else begin
                pack[{pix_cnt[1:0], 3'b000} +: LP_PIX_W] <= pixel_data;
                hold_valid <= 1'b0;
              end
            end else begin
              long_flag <= 1'b1;
            end
          end else begin
            hold_valid <= 1'b0;
            state      <= partial ? LP_FLUSH : LP_IDLE;
          end
        end
        LP_FLUSH: begin
          pack <= '0;
          if (rising) begin
            state       <= LP_SKIP;
            gap_pending <= 1'b1;
          end else begin
            state <= LP_IDLE;
          end
        end
        LP_SKIP: begin
          if (!lval) begin
            state <= LP_IDLE;
          end
        end
        default: begin
          state <= LP_IDLE;
        end
      endcase
    end
  end

  linescanner_word_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(LP_FIFO_W)
  ) u_fifo (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_entry),
    .full       (fifo_full),
    .rd_en      (word_ready),
    .rd_data    (fifo_rd),
    .rd_valid   (word_valid),
    .empty      (fifo_empty)
  );

endmodule

// File: tb/tb_linescanner_line_packer.sv
// Directed bench for linescanner_line_packer: drives lines of pixels,
// predicts output words into a scoreboard queue and checks them as the
// consumer accepts them, plus line_count/line_error/overflow checkpoints.
module tb_linescanner_line_packer;

  localparam int LP = 8;
  localparam int FD = 8;

  logic        pixel_clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        lval;
  logic [7:0]  pixel_data;
  logic [31:0] word_data;
  logic        word_sol;
  logic        word_eol;
  logic        word_valid;
  logic        word_ready;
  logic        line_error;
  logic        overflow;
  logic [15:0] line_count;

  int compared   = 0;
  int mismatched = 0;
  int err_pulses = 0;
  int exp_errors = 0;

  logic [33:0] sb [$];

  linescanner_line_packer #(
    .LINE_PIXELS(LP),
    .FIFO_DEPTH (FD)
  ) dut (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .enable     (enable),
    .lval       (lval),
    .pixel_data (pixel_data),
    .word_data  (word_data),
    .word_sol   (word_sol),
    .word_eol   (word_eol),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .line_error (line_error),
    .overflow   (overflow),
    .line_count (line_count)
  );

  // Free-running pixel clock
  always #5 pixel_clock = ~pixel_clock;

  // Global time limit so a stuck design cannot hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  // Predict the words a line of n pixels starting at base should produce
  task automatic pushLine(input int n, input logic [7:0] base);
    int kept;
    int words;
    logic [31:0] data;
    kept  = (n > LP) ? LP : n;
    words = (kept + 3) / 4;
    for (int w = 0; w < words; w++) begin
      data = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < kept) begin
          data[8*k +: 8] = 8'(base + 4 * w + k);
        end
      end
      sb.push_back({(w == 0), (w == words - 1), data});
    end
  endtask

  // Drive one line of n pixels followed by gap idle cycles
  task automatic applyStimulus(input int n, input logic [7:0] base, input logic en, input int gap);
    enable = en;
    for (int i = 0; i < n; i++) begin
      lval       = 1'b1;
      pixel_data = 8'(base + i);
      tick();
    end
    lval       = 1'b0;
    pixel_data = 8'h00;
    repeat (gap) tick();
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      tick();
    end
    repeat (2) tick();
    checkOutput(tag, 64'(sb.size()), 64'd0);
  endtask

  // Consumer-side monitor: score every accepted word and count error pulses
  always @(negedge pixel_clock) begin
    if (!reset) begin
      if (line_error) begin
        err_pulses++;
      end
      if (word_valid && word_ready) begin
        checkOutput("word_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          checkOutput("word", {30'd0, word_sol, word_eol, word_data}, {30'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    lval       = 1'b0;
    pixel_data = 8'h00;
    word_ready = 1'b1;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_word_valid", 64'(word_valid), 64'd0);
    checkOutput("rst_line_error", 64'(line_error), 64'd0);
    checkOutput("rst_overflow",   64'(overflow),   64'd0);
    checkOutput("rst_line_count", 64'(line_count), 64'd0);
    checkOutput("rst_word",       {word_sol, word_eol, word_data}, 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] exact-length line");
    pushLine(8, 8'h01);
    applyStimulus(8, 8'h01, 1'b1, 3);
    waitDrain("t1_drain");
    checkOutput("t1_line_count", 64'(line_count), 64'd1);
    checkOutput("t1_errors", 64'(err_pulses), 64'(exp_errors));

    $display("[TB] short line with partial word");
    pushLine(6, 8'hA0);
    applyStimulus(6, 8'hA0, 1'b1, 3);
    exp_errors += 1;
    waitDrain("t2_drain");
    checkOutput("t2_line_count", 64'(line_count), 64'd2);
    checkOutput("t2_errors", 64'(err_pulses), 64'(exp_errors));

    $display("[TB] long line");
    pushLine(10, 8'h10);
    applyStimulus(10, 8'h10, 1'b1, 3);
    exp_errors += 1;
    waitDrain("t3_drain");
    checkOutput("t3_line_count", 64'(line_count), 64'd3);
    checkOutput("t3_errors", 64'(err_pulses), 64'(exp_errors));

    $display("[TB] single-cycle gap after a flushed line");
    pushLine(6, 8'h30);
    applyStimulus(6, 8'h30, 1'b1, 1);
    applyStimulus(8, 8'h40, 1'b1, 3);
    exp_errors += 2;
    waitDrain("gap_drain");
    checkOutput("gap_line_count", 64'(line_count), 64'd4);
    checkOutput("gap_errors", 64'(err_pulses), 64'(exp_errors));
    checkOutput("pre_ovf_overflow", 64'(overflow), 64'd0);

    $display("[TB] backpressure overflow");
    word_ready = 1'b0;
    for (int l = 0; l < 6; l++) begin
      if (l < 4) begin
        pushLine(8, 8'(8'h50 + 8'h10 * l));
      end
      applyStimulus(8, 8'(8'h50 + 8'h10 * l), 1'b1, 3);
    end
    exp_errors += 2;
    checkOutput("ovf_overflow",   64'(overflow),   64'd1);
    checkOutput("ovf_line_count", 64'(line_count), 64'd10);
    checkOutput("ovf_errors",     64'(err_pulses), 64'(exp_errors));
    checkOutput("ovf_valid",      64'(word_valid), 64'd1);
    checkOutput("ovf_head",       {30'd0, word_sol, word_eol, word_data}, {30'd0, sb[0]});
    repeat (3) tick();
    checkOutput("ovf_head_stable", {30'd0, word_sol, word_eol, word_data}, {30'd0, sb[0]});
    word_ready = 1'b1;
    waitDrain("ovf_drain");

    $display("[TB] enable low at line start");
    pushLine(8, 8'hB0);
    applyStimulus(8, 8'hB0, 1'b1, 3);
    applyStimulus(8, 8'hC0, 1'b0, 3);
    pushLine(8, 8'hD0);
    applyStimulus(8, 8'hD0, 1'b1, 3);
    waitDrain("en_drain");
    checkOutput("en_line_count", 64'(line_count), 64'd12);
    checkOutput("en_errors", 64'(err_pulses), 64'(exp_errors));

    $display("[TB] reset mid-line");
    word_ready = 1'b0;
    enable     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lval       = 1'b1;
      pixel_data = 8'(8'hE0 + i);
      tick();
    end
    checkOutput("mid_valid_before", 64'(word_valid), 64'd1);
    reset = 1'b1;
    tick();
    sb.delete();
    checkOutput("mid_valid_after", 64'(word_valid), 64'd0);
    checkOutput("mid_line_count",  64'(line_count), 64'd0);
    checkOutput("mid_overflow",    64'(overflow),   64'd0);
    reset      = 1'b0;
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lval       = 1'b1;
      pixel_data = 8'(8'hE8 + i);
      tick();
    end
    lval       = 1'b0;
    pixel_data = 8'h00;
    repeat (4) tick();
    checkOutput("mid_skip_valid", 64'(word_valid), 64'd0);
    checkOutput("mid_skip_count", 64'(line_count), 64'd0);
    pushLine(8, 8'hF0);
    applyStimulus(8, 8'hF0, 1'b1, 3);
    waitDrain("post_rst_drain");
    checkOutput("post_rst_count",  64'(line_count), 64'd1);
    checkOutput("post_rst_errors", 64'(err_pulses), 64'(exp_errors));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
